// File: rtl/game_sched.sv
// Two-player turn scheduler for a shared counter game: grants turns, forwards the owner's
// controls, handles game-over/restart. Optional win counters with GAME_SCHED_STATS_EN.
module game_sched #(
    parameter int WIDTH    = 4,
    parameter int TURN_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_0,
    input  logic             req_1,
    input  logic [1:0]       ctrl_0,
    input  logic [1:0]       ctrl_1,
    input  logic             load_0,
    input  logic             load_1,
    input  logic [WIDTH-1:0] val_0,
    input  logic [WIDTH-1:0] val_1,
    output logic [1:0]       gnt,
    input  logic             winner,
    input  logic             loser,
    input  logic             gameover,
    input  logic             restart,
    output logic [1:0]       ctrl,
    output logic             init,
    output logic [WIDTH-1:0] val,
    output logic             game_rst,
`ifdef GAME_SCHED_STATS_EN
    output logic [7:0]       wins_0,
    output logic [7:0]       wins_1,
`endif
    output logic [2:0]       state_dbg
);
    // Count modes: UP_1=0, UP_2=1, DOWN_1=2, DOWN_2=3.
    localparam logic [1:0] UP_1 = 2'b00;

    typedef enum logic [2:0] {IDLE, PLAY, SWITCH, OVER, CLEAR} state_t;

    state_t           state, state_d;
    logic             owner, owner_d;
    logic             last_owner;
    logic [7:0]       timer;
    logic             clr_cnt;
    logic [1:0]       ctrl_hold;
    logic             init_q;
    logic [WIDTH-1:0] val_q;
    logic             rst_q;

    logic             own_req, other_req, own_load, turn_end, accept_load;
    logic [1:0]       own_ctrl;
    logic [WIDTH-1:0] own_val;

    // Handshake: a player holds req high as long as it wants the game; gnt[p] high means
    // player p owns it this cycle, and dropping req while granted ends the turn.
    assign own_req     = owner ? req_1  : req_0;
    assign other_req   = owner ? req_0  : req_1;
    assign own_ctrl    = owner ? ctrl_1 : ctrl_0;
    assign own_load    = owner ? load_1 : load_0;
    assign own_val     = owner ? val_1  : val_0;
    assign turn_end    = (timer == 8'(TURN_LEN - 1)) || winner || loser || !own_req;
    // A load only becomes an init if the turn carries on, so init never shows with gnt = 0.
    assign accept_load = (state == PLAY) && own_load && (state_d == PLAY);

    always_comb begin
        state_d = state;
        owner_d = owner;
        case (state)
            IDLE: begin
                if (req_0 || req_1) begin
                    state_d = PLAY;
                    owner_d = (req_0 && req_1) ? ~last_owner : req_1;
                end
            end
            PLAY: begin
                if (turn_end) state_d = SWITCH;
            end
            SWITCH: begin
                if (other_req) begin
                    state_d = PLAY;
                    owner_d = ~owner;
                end else if (own_req) begin
                    state_d = PLAY;
                end else begin
                    state_d = IDLE;
                end
            end
            OVER: begin
                if (restart) state_d = CLEAR;
            end
            CLEAR: begin
                if (clr_cnt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (gameover && (state == IDLE || state == PLAY || state == SWITCH)) state_d = OVER;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            timer      <= 8'd0;
            clr_cnt    <= 1'b0;
            ctrl_hold  <= UP_1;
            init_q     <= 1'b0;
            val_q      <= '0;
            rst_q      <= 1'b1;
        end else begin
            state   <= state_d;
            owner   <= owner_d;
            rst_q   <= 1'b0;
            timer   <= (state == PLAY && state_d == PLAY) ? timer + 8'd1 : 8'd0;
            clr_cnt <= (state == CLEAR) ? ~clr_cnt : 1'b0;
            init_q  <= accept_load;
            if (accept_load) val_q <= own_val;
            if (state == PLAY) ctrl_hold <= own_ctrl;
            else if (state == CLEAR) ctrl_hold <= UP_1;
            if (state == SWITCH) last_owner <= owner;
            else if (state == CLEAR) last_owner <= 1'b1;
        end
    end

`ifdef GAME_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            wins_0 <= 8'd0;
            wins_1 <= 8'd0;
        end else if (state == PLAY && winner) begin
            if (!owner && wins_0 != 8'hFF) wins_0 <= wins_0 + 8'd1;
            if (owner && wins_1 != 8'hFF) wins_1 <= wins_1 + 8'd1;
        end
    end
`endif

    assign gnt       = (state == PLAY) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign ctrl      = (state == PLAY) ? own_ctrl : (state == CLEAR) ? UP_1 : ctrl_hold;
    assign init      = init_q;
    assign val       = val_q;
    assign game_rst  = rst_q || (state == CLEAR);
    assign state_dbg = state;
endmodule

// File: tb/tb_game_sched.sv
// Bench for game_sched: a cycle-by-cycle vector table plus hand-written sequences for
// timeout, contention and mid-turn reset.
module tb_game_sched;
    localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_SWITCH = 3'd2, S_OVER = 3'd3, S_CLEAR = 3'd4;

    logic       clk = 1'b0;
    logic       rst, req_0, req_1, load_0, load_1, winner, loser, gameover, restart;
    logic [1:0] ctrl_0, ctrl_1, gnt, ctrl;
    logic [3:0] val_0, val_1, val;
    logic       init, game_rst;
    logic [2:0] state_dbg;
`ifdef GAME_SCHED_STATS_EN
    logic [7:0] wins_0, wins_1;
`endif

    int total = 0;
    int bad   = 0;

    game_sched #(.WIDTH(4), .TURN_LEN(8)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .ctrl_0(ctrl_0), .ctrl_1(ctrl_1),
        .load_0(load_0), .load_1(load_1), .val_0(val_0), .val_1(val_1),
        .gnt(gnt), .winner(winner), .loser(loser), .gameover(gameover), .restart(restart),
        .ctrl(ctrl), .init(init), .val(val), .game_rst(game_rst),
`ifdef GAME_SCHED_STATS_EN
        .wins_0(wins_0), .wins_1(wins_1),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, req0, req1;
        logic [1:0] c0, c1;
        logic       ld0, ld1;
        logic [3:0] v0, v1;
        logic       win, los, go, rs;
        logic [1:0] e_gnt, e_ctrl;
        logic       e_init;
        logic [3:0] e_val;
        logic       e_grst;
        logic [2:0] e_state;
    } vec_t;

    vec_t tbl[$];
    logic [1:0] exp_q[$];

    function automatic vec_t mk(input logic r, q0, q1, input logic [1:0] c0, c1,
                                input logic l0, l1, input logic [3:0] v0, v1,
                                input logic w, lo, go, rs, input logic [1:0] eg, ec,
                                input logic ei, input logic [3:0] ev, input logic er,
                                input logic [2:0] es);
        vec_t t;
        t.rst = r; t.req0 = q0; t.req1 = q1; t.c0 = c0; t.c1 = c1; t.ld0 = l0; t.ld1 = l1;
        t.v0 = v0; t.v1 = v1; t.win = w; t.los = lo; t.go = go; t.rs = rs;
        t.e_gnt = eg; t.e_ctrl = ec; t.e_init = ei; t.e_val = ev; t.e_grst = er; t.e_state = es;
        return t;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; req_0 = 1'b0; req_1 = 1'b0; ctrl_0 = 2'd0; ctrl_1 = 2'd0;
        load_0 = 1'b0; load_1 = 1'b0; val_0 = 4'd0; val_1 = 4'd0;
        winner = 1'b0; loser = 1'b0; gameover = 1'b0; restart = 1'b0;
    endtask

    task automatic apply(input vec_t t);
        rst = t.rst; req_0 = t.req0; req_1 = t.req1; ctrl_0 = t.c0; ctrl_1 = t.c1;
        load_0 = t.ld0; load_1 = t.ld1; val_0 = t.v0; val_1 = t.v1;
        winner = t.win; loser = t.los; gameover = t.go; restart = t.rs;
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int cnt;
        clear_inputs();

        //        rst q0 q1 c0 c1 l0 l1 v0 v1 w lo go rs | gnt ctrl init val grst state
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 1, S_IDLE));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 1, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, 0, S_IDLE));
        tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2, 0, 4'h0, 0, S_PLAY));
        tbl.push_back(mk(0, 1, 0, 2, 0, 1, 1, 4'hA, 4'h5, 0, 0, 0, 0, 2'b01, 2, 1, 4'hA, 0, S_PLAY));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3, 0, 4'hA, 0, S_PLAY));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 1, 0, 4'h5, 0, 0, 0, 0, 2'b01, 3, 0, 4'hA, 0, S_PLAY));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3, 0, 4'hA, 0, S_SWITCH));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3, 0, 4'hA, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 4'hA, 0, S_PLAY));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 4'h7, 0, 0, 1, 0, 2'b00, 1, 0, 4'hA, 0, S_OVER));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 4'hA, 0, S_OVER));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'hA, 1, S_CLEAR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'hA, 1, S_CLEAR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'hA, 0, S_IDLE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'hA, 0, S_IDLE));
        tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2, 0, 4'hA, 0, S_PLAY));
        tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2, 0, 4'hA, 0, S_SWITCH));
        tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 4'hA, 0, S_PLAY));
        tbl.push_back(mk(0, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 4'hA, 0, S_SWITCH));
        tbl.push_back(mk(0, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2, 0, 4'hA, 0, S_PLAY));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            tick();
            check($sformatf("row%0d gnt", i),      gnt,       tbl[i].e_gnt);
            check($sformatf("row%0d ctrl", i),     ctrl,      tbl[i].e_ctrl);
            check($sformatf("row%0d init", i),     init,      tbl[i].e_init);
            check($sformatf("row%0d val", i),      val,       tbl[i].e_val);
            check($sformatf("row%0d game_rst", i), game_rst,  tbl[i].e_grst);
            check($sformatf("row%0d state", i),    state_dbg, tbl[i].e_state);
        end
`ifdef GAME_SCHED_STATS_EN
        check("wins_0 after table", wins_0, 1);
        check("wins_1 after table", wins_1, 0);
`endif

        // Timeout: 8 PLAY cycles, one SWITCH, then regrant of the same player.
        clear_inputs();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; req_0 = 1'b1;
        tick();
        check("timeout first gnt", gnt, 2'b01);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt == 2'b01) cnt++;
            else break;
        end
        check("timeout play cycles", cnt, 8);
        check("timeout switch state", state_dbg, S_SWITCH);
        tick();
        check("timeout regrant", gnt, 2'b01);

        // Contention: both players requesting alternate full turns.
        clear_inputs();
        rst = 1'b1; tick();
        rst = 1'b0; req_0 = 1'b1; req_1 = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        for (int i = 0; i < 8; i++) exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 19; i++) begin
            tick();
            check($sformatf("contention gnt c%0d", i), gnt, exp_q.pop_front());
        end

        // Mid-turn reset with an init pending: no SWITCH, outputs back to reset values.
        clear_inputs();
        rst = 1'b1; tick();
        rst = 1'b0; req_0 = 1'b1;
        tick(); tick(); tick(); tick();
        load_0 = 1'b1; val_0 = 4'hF;
        tick();
        check("midrst init before", init, 1);
        load_0 = 1'b0; rst = 1'b1;
        tick();
        check("midrst gnt", gnt, 2'b00);
        check("midrst init", init, 0);
        check("midrst game_rst", game_rst, 1);
        check("midrst state", state_dbg, S_IDLE);
        req_0 = 1'b0;
        tick();
        check("midrst game_rst held", game_rst, 1);
        rst = 1'b0;
        tick();
        check("midrst game_rst drop", game_rst, 0);
        check("midrst no switch", state_dbg, S_IDLE);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/game_sched.md
GAME_SCHED -- requirements
Module: game_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the counter width of the game datapath it drives.
REQ-002 The block SHALL have parameter TURN_LEN, default 8, the maximum number of PLAY cycles per turn (legal range 2..255).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have these player ports, with p = 0,1:
- req_p  in  1  player p requests a turn; level-sensitive.
- ctrl_p  in  2  player p count mode (UP_1, UP_2, DOWN_1, DOWN_2, shared package encoding).
- load_p  in  1  player p requests a counter preload; single-cycle pulse.
- val_p  in  WIDTH  player p preload value.
- gnt  out  2  one-hot grant; gnt[p] high while player p owns the game.
REQ-005 The block SHALL have these game-side ports:
- winner  in  1  game WINNER.
- loser  in  1  game LOSER.
- gameover  in  1  game GAMEOVER.
- restart  in  1  operator request to start a new game; single-cycle pulse.
- ctrl  out  2  CTRL driven to the game.
- init  out  1  INIT driven to the game.
- val  out  WIDTH  val driven to the game.
- game_rst  out  1  reset driven to the game.

Function
REQ-006 The FSM SHALL have exactly five states: IDLE, PLAY, SWITCH, OVER, CLEAR.
REQ-007 IDLE: on the first cycle any req_p is high, go to PLAY next cycle with gnt set and turn timer = 0.
- Both requesting: grant the player that is not last_owner (last_owner resets to 1, so player 0 wins first).
REQ-008 PLAY: ctrl SHALL equal the granted player's ctrl_p combinationally; the timer increments every cycle.
REQ-009 PLAY: load_p from the granted player SHALL assert init for exactly one cycle, starting the next cycle, with val = that player's val_p registered.
- load from the non-granted player SHALL be ignored.
REQ-010 PLAY SHALL end, moving to SWITCH next cycle, on the first of:
- timer reaches TURN_LEN-1;
- winner or loser high;
- the granted player's req drops.
REQ-011 SWITCH SHALL last one cycle with gnt = 0, ctrl holding its last value, init = 0, and last_owner updated to the outgoing player. The next state SHALL be:
- PLAY granting the other player if it requests;
- else PLAY regranting the same player if it still requests;
- else IDLE.
REQ-012 gameover high in IDLE, PLAY or SWITCH SHALL force OVER next cycle, overriding every other transition.
- A pending init SHALL be cancelled.
REQ-013 OVER: gnt = 0, init = 0, ctrl holds; stay in OVER until restart is high, then go to CLEAR.
REQ-014 CLEAR SHALL assert game_rst for exactly 2 cycles, set ctrl = UP_1 and last_owner = 1, then go to IDLE.
REQ-015 restart outside OVER SHALL be ignored.
REQ-016 winner and loser in the same cycle SHALL be treated as a single turn end.
REQ-017 gnt SHALL never have both bits high; init SHALL never be high when gnt = 0.

Reset
REQ-018 On rst high at a clock edge, every output SHALL take its reset value on the next cycle:
- state = IDLE, gnt = 0, ctrl = UP_1, init = 0, val = 0, game_rst = 1, timer = 0, last_owner = 1.
REQ-019 rst asserted mid-turn SHALL abort the turn with no SWITCH cycle.
- game_rst SHALL stay high while rst is high and drop the cycle after rst falls.

Configuration
REQ-020 With macro GAME_SCHED_STATS_EN defined, the block SHALL add outputs wins_0 and wins_1 (8 bits each):
- each increments when winner is high in PLAY while that player is granted;
- each saturates at 255;
- each clears on rst and in CLEAR.
REQ-021 Without GAME_SCHED_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-022 Reset and timeout: rst for 2 cycles, then req_0 = 1 held -> gnt = 01 next cycle; SWITCH after exactly 8 PLAY cycles; regranted to player 0.
REQ-023 Contention: req_0 = req_1 = 1 from IDLE -> gnt sequence 01 (8 cycles), 00, 10 (8 cycles), 00, 01.
REQ-024 Preload: player 0 granted, load_0 pulse with val_0 = 4'hA -> init = 1 for one cycle with val = 4'hA; load_1 pulse at the same time -> no effect.
REQ-025 Early end: winner pulse at PLAY cycle 3 -> SWITCH next cycle; with stats enabled, wins_0 increments to 1.
REQ-026 Game over: gameover = 1 during PLAY -> OVER next cycle, gnt = 00; restart pulse -> game_rst high for 2 cycles, ctrl = UP_1, then IDLE.
REQ-027 Mid-turn reset: rst during PLAY cycle 5 -> next cycle gnt = 00, init = 0, game_rst = 1, no SWITCH cycle.
